// File: rtl/ntt_masked_bfu_unmask_out.sv
// Output stage of the masked GS/PWM butterfly: tracks in-flight operations with a tag
// pipeline, unmasks and reduces the results mod Q, and buffers them behind credit-based flow control.
module ntt_masked_bfu_unmask_out #(
  parameter int WIDTH           = 46,
  parameter int REG_SIZE        = 23,
  parameter int Q               = 8380417,
  parameter int GS_LATENCY      = 264,
  parameter int PWM_LATENCY     = 210,
  parameter int PWM_ACC_LATENCY = 263,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      zeroize,
  input  logic                      issue_i,
  input  logic                      pwm_i,
  input  logic                      accumulate_i,
  input  logic [WIDTH-1:0][1:0]     u_i,
  input  logic [WIDTH-1:0][1:0]     v_i,
  output logic                      in_ready_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [REG_SIZE-1:0]       u_o,
  output logic [REG_SIZE-1:0]       v_o,
  output logic                      err_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [WIDTH-1:0] Q_W  = WIDTH'(Q);
  localparam logic [WIDTH-1:0] Q2_W = WIDTH'(2 * Q);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    KIND_GS      = 2'd0,
    KIND_PWM     = 2'd1,
    KIND_PWM_ACC = 2'd2
  } kind_e;

  typedef struct packed {
    logic  valid;
    kind_e kind;
  } tag_t;

  typedef struct packed {
    logic [REG_SIZE-1:0] u;
    logic [REG_SIZE-1:0] v;
  } coef_pair_t;

  // Inputs carry one bit of each share per element; split them and add mod 2^WIDTH.
  function automatic logic [WIDTH-1:0] recombine(input logic [WIDTH-1:0][1:0] sh);
    logic [WIDTH-1:0] s0;
    logic [WIDTH-1:0] s1;
    for (int i = 0; i < WIDTH; i++) begin
      s0[i] = sh[i][0];
      s1[i] = sh[i][1];
    end
    return s0 + s1;
  endfunction

  // Returns {out_of_range, coefficient}; a single conditional subtract covers [0, 2Q).
  function automatic logic [REG_SIZE:0] reduce(input logic [WIDTH-1:0] x);
    if (x < Q_W)       return {1'b0, REG_SIZE'(x)};
    else if (x < Q2_W) return {1'b0, REG_SIZE'(x - Q_W)};
    else               return {1'b1, {REG_SIZE{1'b0}}};
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  tag_t [GS_LATENCY-1:0] tag_q;
  tag_t                  new_tag;
  tag_t                  tap_gs, tap_pwm, tap_acc;
  logic                  due_gs, due_pwm, due_acc, any_due, collision;
  logic                  issue_ok, issue_reject;
  logic [REG_SIZE:0]     u_red, v_red;

  logic                  cap_valid_q;
  coef_pair_t            cap_q;

  coef_pair_t            mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      occ_q, cnt_q;
  logic                  fifo_full, pop, push_ok, push_drop;
  logic                  err_q, err_set;

  assign in_ready_o   = (cnt_q < DEPTH_C);
  assign issue_ok     = issue_i & in_ready_o;
  assign issue_reject = issue_i & ~in_ready_o;

  // NOTE: every signal assigned here gets a value on every path (defaults first), so no latch is inferred.
  always_comb begin
    new_tag       = '0;
    new_tag.valid = issue_ok;
    if (pwm_i) new_tag.kind = accumulate_i ? KIND_PWM_ACC : KIND_PWM;
    else       new_tag.kind = KIND_GS;
  end

  // Stage k holds a tag issued k+1 edges ago, so stage L-1 is due on the L-th edge.
  assign tap_gs    = tag_q[GS_LATENCY-1];
  assign tap_pwm   = tag_q[PWM_LATENCY-1];
  assign tap_acc   = tag_q[PWM_ACC_LATENCY-1];
  assign due_gs    = tap_gs.valid  && (tap_gs.kind  == KIND_GS);
  assign due_pwm   = tap_pwm.valid && (tap_pwm.kind == KIND_PWM);
  assign due_acc   = tap_acc.valid && (tap_acc.kind == KIND_PWM_ACC);
  assign any_due   = due_gs | due_pwm | due_acc;
  assign collision = (due_gs & due_pwm) | (due_gs & due_acc) | (due_pwm & due_acc);

  assign u_red = reduce(recombine(u_i));
  assign v_red = reduce(recombine(v_i));

  // NOTE: nonblocking assignment, so each stage takes its neighbour's pre-edge value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     tag_q <= '0;
    else if (zeroize) tag_q <= '0;
    else              tag_q <= {tag_q[GS_LATENCY-2:0], new_tag};
  end

  // Colliding taps all see the same butterfly output, so one capture serves them all.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_valid_q <= 1'b0;
      cap_q       <= '0;
    end else if (zeroize) begin
      cap_valid_q <= 1'b0;
      cap_q       <= '0;
    end else begin
      cap_valid_q <= any_due;
      if (any_due) begin
        cap_q.u <= u_red[REG_SIZE-1:0];
        cap_q.v <= v_red[REG_SIZE-1:0];
      end
    end
  end

  assign fifo_full = (occ_q == DEPTH_C);
  assign pop       = out_valid_o & out_ready_i;
  assign push_ok   = cap_valid_q & (~fifo_full | pop);
  assign push_drop = cap_valid_q & fifo_full & ~pop;

  // NOTE: the storage is reset too, so the head outputs read zero after reset or zeroize.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else if (zeroize) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= cap_q;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_ok, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (zeroize) begin
      cnt_q <= '0;
    end else begin
      case ({issue_ok, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign err_set = issue_reject | push_drop
                 | (any_due & (collision | u_red[REG_SIZE] | v_red[REG_SIZE]));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     err_q <= 1'b0;
    else if (zeroize) err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  assign out_valid_o = (occ_q != '0);
  assign u_o         = mem_q[rd_ptr_q].u;
  assign v_o         = mem_q[rd_ptr_q].v;
  assign err_o       = err_q;

endmodule

// File: tb/tb_ntt_masked_bfu_unmask_out.sv
// Scoreboard bench for ntt_masked_bfu_unmask_out: a butterfly model drives shares at each
// tag's due edge, expected coefficients are queued at issue and compared at every pop.
module tb_ntt_masked_bfu_unmask_out;

  localparam int W    = 46;
  localparam int RS   = 23;
  localparam longint QV = 8380417;
  localparam int L_GS = 264;
  localparam int L_PWM = 210;
  localparam int L_ACC = 263;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              zeroize;
  logic              issue_i, pwm_i, accumulate_i;
  logic [W-1:0][1:0] u_i, v_i;
  logic              in_ready_o, out_valid_o, out_ready_i;
  logic [RS-1:0]     u_o, v_o;
  logic              err_o;

  ntt_masked_bfu_unmask_out dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .zeroize      (zeroize),
    .issue_i      (issue_i),
    .pwm_i        (pwm_i),
    .accumulate_i (accumulate_i),
    .u_i          (u_i),
    .v_i          (v_i),
    .in_ready_o   (in_ready_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .u_o          (u_o),
    .v_o          (v_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           due;
    logic [W-1:0] u0, u1, v0, v1;
  } sched_t;

  typedef struct {
    logic [RS-1:0] u;
    logic [RS-1:0] v;
  } exp_t;

  sched_t sched_q[$];
  exp_t   sb_q[$];
  int     total = 0;
  int     bad   = 0;
  int     cyc   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] rnd46();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0][1:0] pack(input logic [W-1:0] s0, input logic [W-1:0] s1);
    logic [W-1:0][1:0] p;
    for (int i = 0; i < W; i++) p[i] = {s1[i], s0[i]};
    return p;
  endfunction

  function automatic logic [RS-1:0] ref_coef(input logic [W-1:0] s0, input logic [W-1:0] s1);
    logic [W-1:0] x;
    longint       xl;
    x  = s0 + s1;
    xl = longint'(x);
    if (xl < QV)          return RS'(xl);
    else if (xl < 2 * QV) return RS'(xl - QV);
    else                  return '0;
  endfunction

  // One clock: drive butterfly outputs, check a pop that the coming edge will perform, advance.
  task automatic step();
    u_i = pack(rnd46(), rnd46());
    v_i = pack(rnd46(), rnd46());
    foreach (sched_q[k]) begin
      if (sched_q[k].due == cyc + 1) begin
        u_i = pack(sched_q[k].u0, sched_q[k].u1);
        v_i = pack(sched_q[k].v0, sched_q[k].v1);
      end
    end
    if (out_valid_o && out_ready_i) begin
      if (sb_q.size() == 0) begin
        check("pop_expected", 64'(sb_q.size()), 64'd1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("pop_u", 64'(u_o), 64'(e.u));
        check("pop_v", 64'(v_o), 64'(e.v));
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_issue(input bit pwm, input bit acc,
                          input logic [W-1:0] u0, input logic [W-1:0] u1,
                          input logic [W-1:0] v0, input logic [W-1:0] v1,
                          input bit sched, input bit expect_out);
    sched_t s;
    exp_t   e;
    int     lat;
    lat = pwm ? (acc ? L_ACC : L_PWM) : L_GS;
    issue_i = 1'b1;
    pwm_i = pwm;
    accumulate_i = acc;
    if (sched) begin
      s.due = cyc + 1 + lat;
      s.u0 = u0; s.u1 = u1; s.v0 = v0; s.v1 = v1;
      sched_q.push_back(s);
    end
    if (expect_out) begin
      e.u = ref_coef(u0, u1);
      e.v = ref_coef(v0, v1);
      sb_q.push_back(e);
    end
    step();
    issue_i = 1'b0;
    pwm_i = 1'b0;
    accumulate_i = 1'b0;
  endtask

  // Issue with recombined values split into random share pairs.
  task automatic do_issue_val(input bit pwm, input bit acc, input logic [W-1:0] u_val,
                              input logic [W-1:0] v_val, input bit sched, input bit expect_out);
    logic [W-1:0] u0, v0;
    u0 = rnd46();
    v0 = rnd46();
    do_issue(pwm, acc, u0, u_val - u0, v0, v_val - v0, sched, expect_out);
  endtask

  task automatic drain(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (sb_q.size() > target && n < budget) begin
      step();
      n++;
    end
    check(tag, 64'(sb_q.size()), 64'(target));
  endtask

  task automatic do_zeroize();
    out_ready_i = 1'b0;
    zeroize = 1'b1;
    step();
    zeroize = 1'b0;
    sb_q.delete();
    sched_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  t0;
    bit  seen_valid;
    reset_n = 1'b0;
    zeroize = 1'b0;
    issue_i = 1'b0;
    pwm_i = 1'b0;
    accumulate_i = 1'b0;
    out_ready_i = 1'b0;
    u_i = '0;
    v_i = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    check("rst_in_ready", 64'(in_ready_o), 64'd1);
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_u_o", 64'(u_o), 64'd0);
    check("rst_v_o", 64'(v_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);

    // GS single with exact latency
    t0 = cyc + 1;
    do_issue(1'b0, 1'b0, 46'd5, 46'd8380412, 46'd1, 46'd0, 1'b1, 1'b1);
    run(t0 + L_GS - cyc);
    check("gs_valid_before_265", 64'(out_valid_o), 64'd0);
    step();
    check("gs_valid_at_265", 64'(out_valid_o), 64'd1);
    check("gs_err", 64'(err_o), 64'd0);
    out_ready_i = 1'b1;
    step();
    check("gs_sb_empty", 64'(sb_q.size()), 64'd0);
    check("gs_valid_after_pop", 64'(out_valid_o), 64'd0);

    // pwm then pwm_acc; second result out of range
    do_zeroize();
    out_ready_i = 1'b1;
    do_issue_val(1'b1, 1'b0, 46'(QV + 7), 46'd3, 1'b1, 1'b1);
    do_issue_val(1'b1, 1'b1, {W{1'b1}}, 46'(QV + 7), 1'b1, 1'b1);
    drain("pwm_first_out", 1, 300);
    check("pwm_err_before_acc", 64'(err_o), 64'd0);
    drain("acc_second_out", 0, 200);
    check("acc_err_set", 64'(err_o), 64'd1);

    // credits
    do_zeroize();
    check("zeroize_clears_err", 64'(err_o), 64'd0);
    for (int i = 0; i < 4; i++) do_issue_val(1'b0, 1'b0, 46'(rnd46() % 46'(2 * QV)), 46'(i), 1'b1, 1'b1);
    check("credit_exhausted", 64'(in_ready_o), 64'd0);
    check("credit_err_clear", 64'(err_o), 64'd0);
    do_issue_val(1'b0, 1'b0, 46'd9, 46'd9, 1'b0, 1'b0);
    check("reject_err", 64'(err_o), 64'd1);
    check("reject_in_ready", 64'(in_ready_o), 64'd0);
    run(270);
    check("credit_fifo_valid", 64'(out_valid_o), 64'd1);
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    check("credit_pop_ready", 64'(in_ready_o), 64'd1);
    out_ready_i = 1'b1;
    do_issue_val(1'b0, 1'b0, 46'(QV - 1), 46'(QV), 1'b1, 1'b1);
    out_ready_i = 1'b0;
    check("issue_pop_same_cycle", 64'(in_ready_o), 64'd1);
    do_issue_val(1'b0, 1'b0, 46'd77, 46'(2 * QV - 1), 1'b1, 1'b1);
    check("credit_full_again", 64'(in_ready_o), 64'd0);
    out_ready_i = 1'b1;
    drain("credit_drain", 0, 400);
    check("credit_ready_after_drain", 64'(in_ready_o), 64'd1);

    // collision: GS at t0, pwm at t0+54, both due at t0+264
    do_zeroize();
    out_ready_i = 1'b1;
    do_issue_val(1'b0, 1'b0, 46'd1, 46'd1, 1'b0, 1'b0);
    run(53);
    do_issue_val(1'b1, 1'b0, 46'd12345, 46'(QV - 1), 1'b1, 1'b1);
    drain("collision_out", 0, 300);
    run(5);
    check("collision_single", 64'(sb_q.size()), 64'd0);
    check("collision_err", 64'(err_o), 64'd1);

    // zeroize mid-flight; butterfly keeps driving at the due edges
    do_zeroize();
    out_ready_i = 1'b1;
    t0 = cyc + 1;
    do_issue_val(1'b0, 1'b0, 46'd10, 46'd20, 1'b1, 1'b0);
    do_issue_val(1'b1, 1'b0, 46'd30, 46'd40, 1'b1, 1'b0);
    do_issue_val(1'b1, 1'b1, 46'd50, 46'd60, 1'b1, 1'b0);
    run(t0 + 99 - cyc);
    zeroize = 1'b1;
    step();
    zeroize = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      seen_valid |= out_valid_o;
    end
    check("zeroize_no_valid", 64'(seen_valid), 64'd0);
    check("zeroize_in_ready", 64'(in_ready_o), 64'd1);
    check("zeroize_err", 64'(err_o), 64'd0);
    sched_q.delete();

    // same again with an asynchronous reset pulse between edges
    t0 = cyc + 1;
    do_issue_val(1'b0, 1'b0, 46'd11, 46'd21, 1'b1, 1'b0);
    do_issue_val(1'b1, 1'b0, 46'd31, 46'd41, 1'b1, 1'b0);
    do_issue_val(1'b1, 1'b1, 46'(QV * 3), 46'd61, 1'b1, 1'b0);
    run(t0 + 99 - cyc);
    #1 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    @(negedge clk);
    cyc++;
    seen_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      seen_valid |= out_valid_o;
    end
    check("reset_no_valid", 64'(seen_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready_o), 64'd1);
    check("reset_err", 64'(err_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ntt_masked_bfu_unmask_out.md
# ntt_masked_bfu_unmask_out

Downstream companion of the masked GS/PWM butterfly. Tracks each issued butterfly operation through the butterfly's fixed latency, because the butterfly carries no valid signal of its own. When a result arrives, it recombines the two arithmetic shares of u and v, reduces each to a canonical coefficient mod Q, and buffers the pair in a small FIFO. Flow control toward the NTT controller is credit-based, since the butterfly pipeline cannot stall.

## Interface
- WIDTH, 46: share width.
- REG_SIZE, 23: output coefficient width.
- Q, 8380417: modulus.
- GS_LATENCY, 264: issue-to-result cycles, GS mode.
- PWM_LATENCY, 210: issue-to-result cycles, pwm without accumulate.
- PWM_ACC_LATENCY, 263: issue-to-result cycles, pwm with accumulate.
- FIFO_DEPTH, 4: output buffer entries; also the credit limit.
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- zeroize  in  1  synchronous clear of all state, priority over all other inputs.
- issue_i  in  1  an operation enters the butterfly this cycle.
- pwm_i  in  1  operation is pwm; 0 = GS.
- accumulate_i  in  1  pwm accumulate; ignored when pwm_i=0.
- u_i  in  [1:0] x WIDTH  butterfly u shares; element i holds bit i of share0 and share1.
- v_i  in  [1:0] x WIDTH  butterfly v shares, same format.
- in_ready_o  out  1  a credit is available.
- out_valid_o  out  1  FIFO head valid.
- out_ready_i  in  1  consumer accepts the head.
- u_o  out  REG_SIZE  unmasked u mod Q.
- v_o  out  REG_SIZE  unmasked v mod Q.
- err_o  out  1  sticky error.

## Operation
**Tag pipeline**
- Shift register of GS_LATENCY stages. Each stage carries {valid, kind}, where kind is gs, pwm or pwm_acc.
- Stage 0 is loaded with {issue_i, kind}.
- A result is due when a matching tag reaches tap GS_LATENCY, PWM_LATENCY or PWM_ACC_LATENCY.
- The tap is taken at the stage giving exactly that latency relative to the issue edge.

**Capture**
- On a due tag, u_i and v_i are sampled. Bits are repacked to share0/share1.
- Recombination: x = (share0 + share1) mod 2^WIDTH.
- Reduction:
  - x < Q: coefficient = x.
  - Q ≤ x < 2Q: coefficient = x − Q.
  - x ≥ 2Q: coefficient = 0, and err_o is set.
- Result goes to a capture register, then is pushed into the FIFO the next cycle.

**Collision**
- Two or more taps due in the same cycle: the lowest-latency tap is captured, the others are dropped, and err_o is set.

**Credits**
- Counter cnt in 0..FIFO_DEPTH.
- Incremented on issue_i; decremented on pop (out_valid_o & out_ready_i); unchanged when both happen in one cycle.
- in_ready_o = (cnt < FIFO_DEPTH).
- issue_i while in_ready_o=0: the issue is ignored (no tag, no increment) and err_o is set.

**FIFO and errors**
- First-word-fall-through; u_o and v_o show the head.
- Overflow is unreachable under credits. If a push finds the FIFO full, the push is dropped and err_o is set.
- err_o clears only by reset or zeroize.

## Timing
**Reset / zeroize values**
- Tags, cnt, capture register, FIFO and err_o are all cleared.
- Output values: in_ready_o=1, out_valid_o=0, u_o=0, v_o=0, err_o=0.
- A reset or zeroize mid-flight discards every outstanding tag. Butterfly outputs that arrive afterwards are ignored.

**Latency**
- Issue at edge t with latency L: the result is sampled at edge t+L, is in the capture register after t+L, and enters the FIFO at edge t+L+1.
- With the FIFO empty, out_valid_o is high in the cycle following edge t+L+1.

**Throughput and boundaries**
- One issue per cycle is sustained while credits allow.
- Push and pop in the same cycle with the FIFO full: both occur; occupancy is unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- Mixed kinds issued back-to-back may collide. Avoiding this is the controller's responsibility; the block only flags it.
- u_o and v_o hold their value while out_valid_o=1 and out_ready_i=0.

## Test plan
- **GS single:** issue GS at t0. At t0+264 drive u shares (5, 8380412) and v shares (1, 0). Required: out_valid_o asserted at t0+265 (i.e. high in the cycle following edge t0+265), u_o=0, v_o=1, err_o=0.
- **pwm vs pwm_acc:** issue pwm at t0 and pwm_acc at t0+1 (due at t0+210 and t0+264); drive recombined values Q+7 and 2^WIDTH−1 (≥2Q). Required: FIFO outputs 7, then 0, with err_o set at the second capture.
- **Credits:** out_ready_i=0 and 4 GS issues. Required: in_ready_o=0 after the 4th. A 5th issue is ignored and sets err_o. One pop re-raises in_ready_o; simultaneous issue+pop keeps cnt at 4.
- **Collision:** issue GS at t0 and pwm at t0+54, so both are due at t0+264. Required: only the pwm result is captured and err_o=1.
- **Zeroize mid-flight:** issue 3 ops, zeroize at t0+100, keep driving butterfly outputs. Required: no out_valid_o ever, in_ready_o=1, err_o=0. Repeat with reset_n pulsed asynchronously between edges; same result.
